reg_packet_bridge: RTL and testbench
====================================

// Module: reg_packet_bridge
//
// PURPOSE
// - Upstream master of the memory-mapped register file.
// - Decodes a byte stream from the UART receiver into register transactions:
//   single-cycle writes, and reads with a registered return path.
// - Serialises read responses back to the UART transmitter.
// - Sole driver of the register bus address, write data and write enable.
//
// PARAMETERS
// - TIMEOUT_CYCLES  50000  idle clocks allowed between bytes of one packet
//                          before the partial packet is discarded
//
// PORTS
// - ipClk       in   1   system clock; all logic is on the rising edge
// - ipReset     in   1   asynchronous, active-low reset
// - ipRxData    in   8   received byte
// - ipRxValid   in   1   one-cycle strobe: ipRxData is valid; no backpressure
// - opTxData    out  8   byte to transmit
// - opTxValid   out  1   opTxData is valid; held until accepted
// - ipTxReady   in   1   transmitter accepts a byte when opTxValid && ipTxReady
// - opAddress   out  8   register bus address
// - opWrData    out  32  register bus write data
// - opWrEnable  out  1   one-cycle register write strobe
// - ipRdData    in   32  register bus read data; registered, valid 1 clk after
//                        the register file samples opAddress
//
// BEHAVIOUR
// - Packet format: 0x55 sync, cmd, addr, then 4 data bytes LSB first
//   (write only). cmd 0x00 = read, cmd 0x01 = write.
// - Read response: 0x55, 0x00, addr, then rd[7:0], rd[15:8], rd[23:16], rd[31:24].
// - Reset (async assert, sync release): state IDLE; outputs opTxValid=0,
//   opTxData=0, opAddress=0, opWrData=0, opWrEnable=0; timeout counter 0.
// - States and transitions:
//   - IDLE: a byte of 0x55 goes to CMD; any other byte is ignored.
//   - CMD: 0x00 or 0x01 is latched and goes to ADDR; any other value returns to IDLE.
//   - ADDR: the byte is loaded into opAddress that same edge. Read goes to RD_WAIT;
//     write goes to DATA with byte index 0.
//   - DATA: byte k fills opWrData[8k+7:8k]. After k=3 goes to WRITE.
//   - WRITE: opWrEnable=1 for exactly 1 clk, then IDLE. opAddress/opWrData are held.
//   - RD_WAIT: 1 clk.
//   - RD_CAPTURE: latch ipRdData. This is exactly 2 clks after the opAddress
//     update. Then TX, index 0.
//   - TX: present response byte[index] on opTxData with opTxValid=1. On accept,
//     index+1. After index 6 is accepted: opTxValid=0, go to IDLE.
// - opTxValid/opTxData must not change while opTxValid && !ipTxReady.
// - ipRxValid in RD_WAIT, RD_CAPTURE, TX or WRITE: the byte is dropped, with no
//   state change.
// - Timeout: counter clears on every ipRxValid and in IDLE. It increments in
//   CMD/ADDR/DATA. At TIMEOUT_CYCLES the packet is discarded: go to IDLE, no
//   write occurs.
// - A 0x55 received mid-packet is data, not a resync. Recovery from a bad
//   stream is by timeout only.
// - opAddress holds its last value in IDLE (the register file reads it freely).
// - Reset asserted mid-packet or mid-response: abort immediately. No write
//   strobe; opTxValid drops asynchronously.
//
// STRUCTURE
// - Add to package Structures:
//   - typedef enum BRIDGE_STATE {IDLE, CMD, ADDR, DATA, WRITE, RD_WAIT,
//     RD_CAPTURE, TX}
//   - localparams PKT_SYNC=8'h55, CMD_READ=8'h00, CMD_WRITE=8'h01
// - Single module. Byte index (3 b) is shared by DATA and TX.
// - Timeout counter width: $clog2(TIMEOUT_CYCLES+1).
//
// TESTING
// 1. Rx 55 01 02 EF BE AD DE -> one opWrEnable pulse with opAddress=02,
//    opWrData=DEADBEEF; no Tx activity.
// 2. Registers model returns 12345678 at addr 03; Rx 55 00 03 -> Tx bytes
//    55 00 03 78 56 34 12. ipRdData is sampled 2 clks after opAddress=03.
// 3. Test 2 with ipTxReady low for 5 clks on every byte -> same byte sequence,
//    opTxData stable while stalled, no byte duplicated or skipped.
// 4. Rx 55 01 02 AA, then silence for TIMEOUT_CYCLES -> no write, state IDLE.
//    Next 55 00 02 gets a normal response.
// 5. Rx 55 07 -> back to IDLE. Rx 55 00 01 -> correct response. Bytes injected
//    during TX are dropped.
// 6. Assert ipReset low during DATA byte 2 and during TX byte 4 -> outputs at
//    reset values immediately; no opWrEnable; clean packet afterwards works.

Source files
------------

// File: rtl/reg_packet_bridge_pkg.sv
// reg_packet_bridge_pkg: shared state encoding, packet constants and response byte selection
// Package Structures
//   BRIDGE_STATE  bridge FSM states
//   PKT_SYNC      sync byte that opens requests and responses
//   CMD_READ      read command byte
//   CMD_WRITE     write command byte
//   resp_byte     byte idx of a read response: sync, cmd, addr, then rd LSB first
package Structures;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WRITE, RD_WAIT, RD_CAPTURE, TX} BRIDGE_STATE;
    localparam logic [7:0] PKT_SYNC  = 8'h55;
    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    function automatic logic [7:0] resp_byte(input logic [2:0] idx, input logic [7:0] addr, input logic [31:0] rd);
        logic [1:0] k;
        k = idx[1:0] + 2'd1;
        return idx == 3'd0 ? PKT_SYNC : idx == 3'd1 ? CMD_READ : idx == 3'd2 ? addr : rd[{k, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/reg_packet_bridge.sv
// reg_packet_bridge: UART byte stream to register bus master with serialised read responses
// Ports
//   ipClk       in   1   system clock, rising edge
//   ipReset     in   1   asynchronous active-low reset
//   ipRxData    in   8   received byte
//   ipRxValid   in   1   one-cycle strobe for ipRxData
//   opTxData    out  8   byte to transmit
//   opTxValid   out  1   opTxData valid, held until accepted
//   ipTxReady   in   1   transmitter accepts when opTxValid && ipTxReady
//   opAddress   out  8   register bus address, held between packets
//   opWrData    out  32  register bus write data
//   opWrEnable  out  1   one-cycle write strobe
//   ipRdData    in   32  registered read data, valid 1 clk after opAddress is sampled
module reg_packet_bridge
    import Structures::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  logic [7:0]  ipRxData,
    input  logic        ipRxValid,
    output logic [7:0]  opTxData,
    output logic        opTxValid,
    input  logic        ipTxReady,
    output logic [7:0]  opAddress,
    output logic [31:0] opWrData,
    output logic        opWrEnable,
    input  logic [31:0] ipRdData
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    BRIDGE_STATE state, state_nx;
    logic          is_write;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [31:0]   rd_word;
    logic          rx_stage;
    logic          timed_out;

    // Only the packet-receiving states accept bytes or age the timeout.
    assign rx_stage  = state == CMD || state == ADDR || state == DATA;
    assign timed_out = rx_stage && !ipRxValid && cnt == CW'(TIMEOUT_CYCLES);

    // Decoded from state so reset drops them asynchronously.
    assign opWrEnable = state == WRITE;
    assign opTxValid  = state == TX;
    assign opTxData   = state == TX ? resp_byte(idx, opAddress, rd_word) : 8'h00;

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = ipRxValid && ipRxData == PKT_SYNC ? CMD : IDLE;
            CMD:        if (ipRxValid) state_nx = ipRxData == CMD_READ || ipRxData == CMD_WRITE ? ADDR : IDLE;
            ADDR:       if (ipRxValid) state_nx = is_write ? DATA : RD_WAIT;
            DATA:       if (ipRxValid && idx == 3'd3) state_nx = WRITE;
            WRITE:      state_nx = IDLE;
            RD_WAIT:    state_nx = RD_CAPTURE;
            RD_CAPTURE: state_nx = TX;
            TX:         if (ipTxReady && idx == 3'd6) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
        if (timed_out) state_nx = IDLE;
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            is_write  <= 1'b0;
            idx       <= 3'd0;
            cnt       <= '0;
            rd_word   <= '0;
            opAddress <= '0;
            opWrData  <= '0;
        end else begin
            cnt <= ipRxValid || state == IDLE ? '0 : rx_stage ? cnt + 1'b1 : cnt;
            if (state == CMD && ipRxValid) is_write <= ipRxData == CMD_WRITE;
            if (state == ADDR && ipRxValid) begin
                opAddress <= ipRxData;
                idx       <= 3'd0;
            end
            if (state == DATA && ipRxValid) begin
                opWrData[{idx[1:0], 3'b000} +: 8] <= ipRxData;
                idx <= idx + 3'd1;
            end
            // Two clocks after the address update: the register file has sampled it and registered its data.
            if (state == RD_CAPTURE) begin
                rd_word <= ipRdData;
                idx     <= 3'd0;
            end
            if (state == TX && ipTxReady) idx <= idx + 3'd1;
        end
    end
endmodule

// File: tb/tb_reg_packet_bridge.sv
// tb_reg_packet_bridge: directed-vector bench for reg_packet_bridge with a registered register-file model
module tb_reg_packet_bridge;
    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  address;
    logic [31:0] wr_data;
    logic        wr_enable;
    logic [31:0] rd_data = 32'h0;

    int          total = 0;
    int          bad = 0;
    int          wr_count = 0;
    logic [7:0]  last_addr = 8'h00;
    logic [31:0] last_data = 32'h0;
    logic [7:0]  tx_q[$];
    int          stall_err = 0;
    bit          stall_mode = 1'b0;
    int          wait_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [31:0] mem[256];
    logic [255:0] wr_ok = '0;

    always #5 clk = ~clk;

    reg_packet_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .ipClk(clk),
        .ipReset(rst_n),
        .ipRxData(rx_data),
        .ipRxValid(rx_valid),
        .opTxData(tx_data),
        .opTxValid(tx_valid),
        .ipTxReady(tx_ready),
        .opAddress(address),
        .opWrData(wr_data),
        .opWrEnable(wr_enable),
        .ipRdData(rd_data)
    );

    function automatic logic [31:0] dflt(input logic [7:0] a);
        return a == 8'h03 ? 32'h12345678 : a == 8'h01 ? 32'hA5A50F0F : {24'hC0DE00, a};
    endfunction

    // Register file: writes land on the strobe edge, reads are registered one clock.
    always @(posedge clk) begin
        if (wr_enable) begin
            mem[address]   <= wr_data;
            wr_ok[address] <= 1'b1;
        end
        rd_data <= wr_ok[address] ? mem[address] : dflt(address);
    end

    // Transmitter: in stall mode each presented byte waits 5 clocks before being accepted.
    always @(posedge clk) begin
        #2;
        if (!stall_mode) tx_ready = 1'b1;
        else if (tx_ready || !tx_valid) begin
            tx_ready = 1'b0;
            wait_cnt = 0;
        end else begin
            wait_cnt = wait_cnt + 1;
            if (wait_cnt == 5) tx_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (wr_enable) begin
            wr_count  = wr_count + 1;
            last_addr = address;
            last_data = wr_data;
        end
        if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_err = stall_err + 1;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] b[$]);
        foreach (b[i]) send(b[i]);
    endtask

    task automatic wait_tx(input int n, input string tag);
        for (int i = 0; i < 400 && tx_q.size() < n; i++) @(negedge clk);
        idle(4);
        check({tag, "_count"}, tx_q.size(), n);
    endtask

    task automatic expect_resp(input logic [7:0] a, input logic [31:0] w, input string tag);
        logic [7:0] e[7];
        e[0] = 8'h55; e[1] = 8'h00; e[2] = a;
        e[3] = w[7:0]; e[4] = w[15:8]; e[5] = w[23:16]; e[6] = w[31:24];
        wait_tx(7, tag);
        for (int i = 0; i < 7; i++)
            check($sformatf("%s_b%0d", tag, i), i < tx_q.size() ? tx_q[i] : 8'hxx, e[i]);
        tx_q.delete();
    endtask

    task automatic check_rst(input string tag);
        check(tag, {tx_valid, tx_data, address, wr_data, wr_enable}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        idle(2);
        check_rst("reset");
        rst_n = 1'b1;
        idle(2);

        send_pkt('{8'h55, 8'h01, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        idle(4);
        check("wr_count1", wr_count, 1);
        check("wr_addr1", last_addr, 8'h02);
        check("wr_data1", last_data, 32'hDEADBEEF);
        check("wr_no_tx", tx_q.size(), 0);

        send_pkt('{8'h55, 8'h00, 8'h03});
        expect_resp(8'h03, 32'h12345678, "rd3");

        stall_mode = 1'b1;
        send_pkt('{8'h55, 8'h00, 8'h03});
        expect_resp(8'h03, 32'h12345678, "stall");
        check("stall_stable", stall_err, 0);
        stall_mode = 1'b0;

        send_pkt('{8'h55, 8'h01, 8'h02, 8'hAA});
        idle(TO + 5);
        check("to_no_wr", wr_count, 1);
        send_pkt('{8'h55, 8'h00, 8'h02});
        expect_resp(8'h02, 32'hDEADBEEF, "to_rd");
        check("to_no_wr2", wr_count, 1);

        send_pkt('{8'h55, 8'h01, 8'h04});
        idle(TO - 5);
        send(8'h11);
        idle(TO - 5);
        send_pkt('{8'h22, 8'h33, 8'h44});
        idle(3);
        check("slow_wr_count", wr_count, 2);
        check("slow_wr_addr", last_addr, 8'h04);
        check("slow_wr_data", last_data, 32'h44332211);

        send_pkt('{8'h55, 8'h07});
        stall_mode = 1'b1;
        send_pkt('{8'h55, 8'h00, 8'h01});
        for (int i = 0; i < 50 && tx_q.size() < 1; i++) @(negedge clk);
        send_pkt('{8'h55, 8'h01, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44});
        expect_resp(8'h01, 32'hA5A50F0F, "drop");
        check("drop_no_wr", wr_count, 2);
        stall_mode = 1'b0;
        idle(4);

        send_pkt('{8'h55, 8'h01, 8'h05, 8'h11, 8'h22});
        #2 rst_n = 1'b0;
        #1 check_rst("rst_data");
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check("rst_data_no_wr", wr_count, 2);

        send_pkt('{8'h55, 8'h00, 8'h03});
        for (int i = 0; i < 50 && tx_q.size() < 4; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_rst("rst_tx");
        idle(2);
        rst_n = 1'b1;
        idle(2);
        tx_q.delete();

        send_pkt('{8'h55, 8'h00, 8'h03});
        expect_resp(8'h03, 32'h12345678, "post");
        check("post_no_wr", wr_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
